// File: rtl/valid_pulse_filter.sv
// valid_pulse_filter: rejects short valid glitches, forwards qualified windows, reports pulse lengths and reject count
module valid_pulse_filter #(
  parameter int MIN_LEN = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             datadelay,
  input  logic             short_clr,
  output logic             validout,
  output logic [CNT_W-1:0] pulse_len,
  output logic             len_valid,
  output logic             short_flag,
  output logic [7:0]       short_cnt
);
  typedef enum logic [1:0] {IDLE, ARM, PASS} state_t;
  state_t state, state_n;
  logic din_r, validout_n, len_valid_n, short_flag_n, short_inc;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc, pulse_len_n;
  logic [7:0] short_cnt_n;
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign short_cnt_n = short_clr ? 8'd0 : (short_inc && !(&short_cnt)) ? short_cnt + 8'd1 : short_cnt;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    validout_n = validout;
    pulse_len_n = pulse_len;
    len_valid_n = 1'b0;
    short_flag_n = short_flag;
    short_inc = 1'b0;
    case (state)
      IDLE: if (din_r) begin
        cnt_n = CNT_W'(1);
        state_n = (MIN_LEN == 1) ? PASS : ARM;
        validout_n = (MIN_LEN == 1);
      end
      ARM: if (din_r) begin
        cnt_n = cnt_inc;
        if (cnt == CNT_W'(MIN_LEN - 1)) begin
          state_n = PASS;
          validout_n = 1'b1;
        end
      end else begin
        len_valid_n = 1'b1;
        short_flag_n = 1'b1;
        pulse_len_n = cnt;
        short_inc = 1'b1;
        state_n = IDLE;
      end
      PASS: if (din_r) begin
        cnt_n = cnt_inc;
      end else begin
        validout_n = 1'b0;
        len_valid_n = 1'b1;
        short_flag_n = 1'b0;
        pulse_len_n = cnt;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      din_r <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      validout <= 1'b0;
      pulse_len <= '0;
      len_valid <= 1'b0;
      short_flag <= 1'b0;
      short_cnt <= 8'd0;
    end else begin
      din_r <= datadelay;
      state <= state_n;
      cnt <= cnt_n;
      validout <= validout_n;
      pulse_len <= pulse_len_n;
      len_valid <= len_valid_n;
      short_flag <= short_flag_n;
      short_cnt <= short_cnt_n;
    end
  end
endmodule

// File: tb/tb_valid_pulse_filter.sv
// tb_valid_pulse_filter: run-length reference model against the filter under directed and random stimulus
module tb_valid_pulse_filter;
  localparam int ML = 3;
  logic clk = 1'b0, rst = 1'b1, datadelay = 1'b0, short_clr = 1'b0;
  logic validout, len_valid, short_flag;
  logic [7:0] pulse_len, short_cnt;
  int n_cmp = 0, n_bad = 0;
  int run_cur = 0, run_prev = 0;
  bit rst_prev = 1'b1;
  int e_valid = 0, e_len = 0, e_lv = 0, e_sf = 0, e_sc = 0;
  int v_hi = 0, lv_n = 0;
  int l, g;
  always #5 clk = ~clk;
  valid_pulse_filter #(.MIN_LEN(ML), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .datadelay(datadelay), .short_clr(short_clr),
    .validout(validout), .pulse_len(pulse_len), .len_valid(len_valid),
    .short_flag(short_flag), .short_cnt(short_cnt)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic cyc(input bit r, input bit d, input bit c);
    int run_new;
    bit inc;
    rst = r;
    datadelay = d;
    short_clr = c;
    @(posedge clk);
    run_new = r ? 0 : d ? run_cur + 1 : 0;
    inc = 1'b0;
    if (r) begin
      e_valid = 0; e_len = 0; e_lv = 0; e_sf = 0; e_sc = 0;
    end else begin
      e_valid = int'(run_cur >= ML);
      e_lv = int'(!rst_prev && run_cur == 0 && run_prev > 0);
      if (e_lv != 0) begin
        e_len = run_prev > 255 ? 255 : run_prev;
        e_sf = int'(run_prev < ML);
        inc = (run_prev < ML);
      end
      e_sc = c ? 0 : inc ? (e_sc == 255 ? 255 : e_sc + 1) : e_sc;
    end
    run_prev = run_cur;
    run_cur = run_new;
    rst_prev = r;
    #1;
    chk("validout", int'(validout), e_valid);
    chk("len_valid", int'(len_valid), e_lv);
    chk("pulse_len", int'(pulse_len), e_len);
    chk("short_flag", int'(short_flag), e_sf);
    chk("short_cnt", int'(short_cnt), e_sc);
    if (validout === 1'b1) v_hi++;
    if (len_valid === 1'b1) lv_n++;
  endtask
  task automatic pulse(input int len, input int gap);
    for (int i = 0; i < len; i++) cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < gap; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    for (int i = 0; i < 10; i++) cyc(1'b1, i[0], 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    v_hi = 0; lv_n = 0;
    pulse(10, 3);
    chk("t2_valid_cycles", v_hi, 8);
    chk("t2_strobes", lv_n, 1);
    chk("t2_len", int'(pulse_len), 10);
    chk("t2_short_cnt", int'(short_cnt), 0);
    v_hi = 0; lv_n = 0;
    for (int i = 0; i < 3; i++) pulse(1, 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t3_valid_cycles", v_hi, 0);
    chk("t3_strobes", lv_n, 3);
    chk("t3_short_cnt", int'(short_cnt), 3);
    v_hi = 0;
    pulse(3, 2);
    chk("t4_valid_cycles", v_hi, 1);
    chk("t4_len3", int'(pulse_len), 3);
    pulse(2, 2);
    chk("t4_len2", int'(pulse_len), 2);
    chk("t4_flag2", int'(short_flag), 1);
    pulse(300, 2);
    chk("t5_len_sat", int'(pulse_len), 255);
    for (int i = 0; i < 260; i++) pulse(1, 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t5_cnt_sat", int'(short_cnt), 255);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("t5_clr_strobe", int'(len_valid), 1);
    chk("t5_clr_wins", int'(short_cnt), 0);
    pulse(6, 0);
    lv_n = 0;
    cyc(1'b1, 1'b1, 1'b0);
    chk("t6_valid_drop", int'(validout), 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk("t6_valid_return", int'(validout), int'(i == 4));
    end
    chk("t6_no_strobe", lv_n, 0);
    pulse(2, 2);
    for (int i = 0; i < 200; i++) begin
      l = $urandom_range(1, 6);
      g = $urandom_range(1, 3);
      for (int j = 0; j < l; j++) cyc($urandom_range(0, 49) == 0, 1'b1, $urandom_range(0, 29) == 0);
      for (int j = 0; j < g; j++) cyc(1'b0, 1'b0, $urandom_range(0, 29) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
